// File: rtl/vx_fpu_rsp_reorder.sv
// rtl/vx_fpu_rsp_reorder.sv - FPU response tag store, issue/completion-order sequencer and fflags CSR accumulator
module vx_fpu_rsp_reorder #(
    parameter int NUM_LANES = 4,
    parameter int XLEN      = 32,
    parameter int DEPTH     = 8,
    parameter int NUM_WARPS = 4,
    parameter int NW_W      = 2,
    parameter int META_W    = 64,
    parameter int IN_ORDER  = 1,
    parameter int TAG_W     = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [NW_W-1:0]           req_wid,
    input  logic [META_W-1:0]         req_meta,
    input  logic                      req_sop,
    input  logic                      req_eop,
    output logic [TAG_W-1:0]          req_tag,
    input  logic                      fpu_rsp_valid,
    output logic                      fpu_rsp_ready,
    input  logic [TAG_W-1:0]          fpu_rsp_tag,
    input  logic [NUM_LANES*XLEN-1:0] fpu_rsp_result,
    input  logic                      fpu_rsp_has_fflags,
    input  logic [4:0]                fpu_rsp_fflags,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NW_W-1:0]           out_wid,
    output logic [META_W-1:0]         out_meta,
    output logic [NUM_LANES*XLEN-1:0] out_result,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      csr_write_enable,
    output logic [NW_W-1:0]           csr_write_wid,
    output logic [4:0]                csr_write_fflags,
    output logic [CNT_W-1:0]          count,
    output logic                      empty
);

    localparam int RES_W = NUM_LANES * XLEN;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_sop;
    logic [DEPTH-1:0]  ent_eop;
    logic [DEPTH-1:0]  ent_has;
    logic [NW_W-1:0]   ent_wid  [DEPTH];
    logic [META_W-1:0] ent_meta [DEPTH];
    logic [4:0]        ent_ff   [DEPTH];
    logic [RES_W-1:0]  ent_res  [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W-1:0]  free_tag;
    logic [TAG_W-1:0]  alloc_tag;
    logic [TAG_W-1:0]  out_tag;
    logic [CNT_W-1:0]  cnt;

    logic [4:0]           acc     [NUM_WARPS];
    logic [NUM_WARPS-1:0] acc_has;

    logic req_fire;
    logic rsp_fire;
    logic rsp_ok;
    logic rsp_wr;
    logic rel;
    logic out_has;
    logic [4:0] out_ff;

    always_comb begin
        free_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) free_tag = TAG_W'(i);
        end
    end

    assign req_ready = (cnt != FULL_CNT);
    assign req_fire  = req_valid & req_ready;
    assign alloc_tag = (IN_ORDER != 0) ? tail : free_tag;
    assign req_tag   = alloc_tag;

    // Reorder mode presents the head once its result is stored; pass-through mode forwards the backend directly.
    always_comb begin
        if (IN_ORDER != 0) begin
            fpu_rsp_ready = 1'b1;
            rsp_fire      = fpu_rsp_valid;
            rsp_ok        = ent_valid[fpu_rsp_tag] & ~ent_done[fpu_rsp_tag];
            out_tag       = head;
            out_valid     = ent_valid[head] & ent_done[head];
            out_result    = ent_res[head];
            out_has       = ent_has[head];
            out_ff        = ent_ff[head];
        end else begin
            fpu_rsp_ready = out_ready;
            rsp_fire      = fpu_rsp_valid & out_ready;
            rsp_ok        = ent_valid[fpu_rsp_tag];
            out_tag       = fpu_rsp_tag;
            out_valid     = fpu_rsp_valid;
            out_result    = fpu_rsp_result;
            out_has       = fpu_rsp_has_fflags;
            out_ff        = fpu_rsp_fflags;
        end
    end

    assign rsp_wr   = (IN_ORDER != 0) & fpu_rsp_valid & rsp_ok;
    assign rel      = out_valid & out_ready & ent_valid[out_tag];
    assign out_wid  = ent_wid[out_tag];
    assign out_meta = ent_meta[out_tag];
    assign out_sop  = ent_sop[out_tag];
    assign out_eop  = ent_eop[out_tag];
    assign count    = cnt;
    assign empty    = (cnt == '0);

    always_ff @(posedge clk) begin
        if (req_fire) begin
            ent_wid[alloc_tag]  <= req_wid;
            ent_meta[alloc_tag] <= req_meta;
            ent_sop[alloc_tag]  <= req_sop;
            ent_eop[alloc_tag]  <= req_eop;
        end
        if (rsp_wr) begin
            ent_res[fpu_rsp_tag] <= fpu_rsp_result;
            ent_has[fpu_rsp_tag] <= fpu_rsp_has_fflags;
            ent_ff[fpu_rsp_tag]  <= fpu_rsp_fflags;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ent_valid        <= '0;
            ent_done         <= '0;
            head             <= '0;
            tail             <= '0;
            cnt              <= '0;
            acc_has          <= '0;
            for (int i = 0; i < NUM_WARPS; i++) acc[i] <= '0;
            csr_write_enable <= 1'b0;
            csr_write_wid    <= '0;
            csr_write_fflags <= '0;
        end else begin
            csr_write_enable <= 1'b0;
            if (rel) begin
                ent_valid[out_tag] <= 1'b0;
                ent_done[out_tag]  <= 1'b0;
                if (IN_ORDER != 0) head <= head + TAG_W'(1);
                // eop flushes the warp's accumulated flags into one CSR write
                if (out_eop) begin
                    csr_write_enable <= out_has | acc_has[out_wid];
                    csr_write_wid    <= out_wid;
                    csr_write_fflags <= acc[out_wid] | (out_has ? out_ff : 5'd0);
                    acc[out_wid]     <= 5'd0;
                    acc_has[out_wid] <= 1'b0;
                end else if (out_has) begin
                    acc[out_wid]     <= acc[out_wid] | out_ff;
                    acc_has[out_wid] <= 1'b1;
                end
            end
            if (rsp_wr) ent_done[fpu_rsp_tag] <= 1'b1;
            if (req_fire) begin
                ent_valid[alloc_tag] <= 1'b1;
                ent_done[alloc_tag]  <= 1'b0;
                if (IN_ORDER != 0) tail <= tail + TAG_W'(1);
            end
            case ({req_fire, rel})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always @(posedge clk) begin
        if (reset_n && rsp_fire) assert (rsp_ok);
    end

endmodule

// File: tb/tb_vx_fpu_rsp_reorder.sv
// tb/tb_vx_fpu_rsp_reorder.sv - reorder (inst 0) and pass-through (inst 1) against a queue-based reference model
module tb_vx_fpu_rsp_reorder;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic         req_valid [2], req_ready [2], req_sop [2], req_eop [2];
    logic         rsp_valid [2], rsp_ready [2], rsp_has [2];
    logic         out_valid [2], out_ready [2], out_sop [2], out_eop [2];
    logic         csr_we [2], empty [2];
    logic [1:0]   req_wid [2], req_tag [2], rsp_tag [2], out_wid [2], csr_wid [2];
    logic [63:0]  req_meta [2], out_meta [2];
    logic [127:0] rsp_result [2], out_result [2];
    logic [4:0]   rsp_ff [2], csr_ff [2];
    logic [2:0]   count [2];

    int checks = 0;
    int errors = 0;
    bit started = 0;

    bit           m_v [2][D], m_done [2][D], m_sop [2][D], m_eop [2][D], m_has [2][D];
    logic [1:0]   m_wid [2][D];
    logic [63:0]  m_meta [2][D];
    logic [127:0] m_res [2][D];
    logic [4:0]   m_ff [2][D];
    int           m_cnt [2];
    int           m_allocs;
    int           m_q [$];
    logic [4:0]   m_acc [2][4];
    bit           m_acch [2][4];
    bit           e_we [2];
    logic [1:0]   e_wid [2];
    logic [4:0]   e_ff [2];

    logic [63:0]  seen0 [$];
    int           pulses [2];
    logic [1:0]   last_wid [2];
    logic [4:0]   last_ff [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vx_fpu_rsp_reorder #(
            .NUM_LANES(4), .XLEN(32), .DEPTH(D), .NUM_WARPS(4), .NW_W(2),
            .META_W(64), .IN_ORDER(g == 0 ? 1 : 0)
        ) u_dut (
            .clk(clk), .reset_n(reset_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_wid(req_wid[g]),
            .req_meta(req_meta[g]), .req_sop(req_sop[g]), .req_eop(req_eop[g]), .req_tag(req_tag[g]),
            .fpu_rsp_valid(rsp_valid[g]), .fpu_rsp_ready(rsp_ready[g]), .fpu_rsp_tag(rsp_tag[g]),
            .fpu_rsp_result(rsp_result[g]), .fpu_rsp_has_fflags(rsp_has[g]), .fpu_rsp_fflags(rsp_ff[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_wid(out_wid[g]),
            .out_meta(out_meta[g]), .out_result(out_result[g]), .out_sop(out_sop[g]), .out_eop(out_eop[g]),
            .csr_write_enable(csr_we[g]), .csr_write_wid(csr_wid[g]), .csr_write_fflags(csr_ff[g]),
            .count(count[g]), .empty(empty[g])
        );
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    function automatic int alloc_tag(int k);
        if (k == 0) return m_allocs % D;
        for (int i = 0; i < D; i++) if (!m_v[1][i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < D; i++) begin
                m_v[k][i] = 0;
                m_done[k][i] = 0;
            end
            for (int w = 0; w < 4; w++) begin
                m_acc[k][w] = 5'd0;
                m_acch[k][w] = 0;
            end
            m_cnt[k] = 0;
            e_we[k] = 0;
        end
        m_allocs = 0;
        m_q.delete();
    endtask

    // Outputs observed at negedge reflect the previous posedge; the model then advances to the next posedge.
    always @(negedge clk) begin : cmp
        int t, w, at;
        bit ov, oh, rf;
        logic [4:0] of;
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("req_ready%0d", k), req_ready[k], m_cnt[k] != D);
                chk($sformatf("count%0d", k), count[k], m_cnt[k]);
                chk($sformatf("empty%0d", k), empty[k], m_cnt[k] == 0);
                if (m_cnt[k] != D) chk($sformatf("req_tag%0d", k), req_tag[k], alloc_tag(k));
                if (k == 0) begin
                    ov = (m_q.size() > 0) && m_done[0][m_q[0]];
                    chk("out_valid0", out_valid[0], ov);
                    chk("rsp_ready0", rsp_ready[0], 1'b1);
                    t = ov ? m_q[0] : -1;
                end else begin
                    chk("out_valid1", out_valid[1], rsp_valid[1]);
                    chk("rsp_ready1", rsp_ready[1], out_ready[1]);
                    t = rsp_valid[1] ? int'(rsp_tag[1]) : -1;
                    if (t >= 0) chk("out_result1", out_result[1], rsp_result[1]);
                end
                if (t >= 0) begin
                    chk($sformatf("out_wid%0d", k), out_wid[k], m_wid[k][t]);
                    chk($sformatf("out_meta%0d", k), out_meta[k], m_meta[k][t]);
                    chk($sformatf("out_sop%0d", k), out_sop[k], m_sop[k][t]);
                    chk($sformatf("out_eop%0d", k), out_eop[k], m_eop[k][t]);
                    if (k == 0) chk("out_result0", out_result[0], m_res[0][t]);
                end
                chk($sformatf("csr_we%0d", k), csr_we[k], e_we[k]);
                if (e_we[k]) begin
                    chk($sformatf("csr_wid%0d", k), csr_wid[k], e_wid[k]);
                    chk($sformatf("csr_ff%0d", k), csr_ff[k], e_ff[k]);
                end
                if (csr_we[k]) begin
                    pulses[k]++;
                    last_wid[k] = csr_wid[k];
                    last_ff[k] = csr_ff[k];
                end
            end
            if (out_valid[0] && out_ready[0]) seen0.push_back(out_meta[0]);
        end
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                e_we[k] = 0;
                rf = req_valid[k] && (m_cnt[k] != D);
                at = alloc_tag(k);
                ov = 0; t = 0; oh = 0; of = 5'd0;
                if (k == 0) begin
                    if (m_q.size() > 0 && m_done[0][m_q[0]]) begin
                        ov = 1; t = m_q[0]; oh = m_has[0][t]; of = m_ff[0][t];
                    end
                end else begin
                    ov = rsp_valid[1]; t = rsp_tag[1]; oh = rsp_has[1]; of = rsp_ff[1];
                end
                if (ov && out_ready[k]) begin
                    w = m_wid[k][t];
                    if (m_eop[k][t]) begin
                        e_we[k] = oh || m_acch[k][w];
                        e_wid[k] = 2'(w);
                        e_ff[k] = m_acc[k][w] | (oh ? of : 5'd0);
                        m_acc[k][w] = 5'd0;
                        m_acch[k][w] = 0;
                    end else if (oh) begin
                        m_acc[k][w] = m_acc[k][w] | of;
                        m_acch[k][w] = 1;
                    end
                    m_v[k][t] = 0;
                    m_done[k][t] = 0;
                    m_cnt[k]--;
                    if (k == 0) void'(m_q.pop_front());
                end
                if (k == 0 && rsp_valid[0]) begin
                    m_done[0][rsp_tag[0]] = 1;
                    m_res[0][rsp_tag[0]] = rsp_result[0];
                    m_has[0][rsp_tag[0]] = rsp_has[0];
                    m_ff[0][rsp_tag[0]] = rsp_ff[0];
                end
                if (rf) begin
                    m_v[k][at] = 1;
                    m_done[k][at] = 0;
                    m_wid[k][at] = req_wid[k];
                    m_meta[k][at] = req_meta[k];
                    m_sop[k][at] = req_sop[k];
                    m_eop[k][at] = req_eop[k];
                    if (k == 0) begin
                        m_q.push_back(at);
                        m_allocs++;
                    end
                    m_cnt[k]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_wid[k] = 2'd0; req_meta[k] = 64'd0; req_sop[k] = 0; req_eop[k] = 0;
            rsp_valid[k] = 0; rsp_tag[k] = 2'd0; rsp_result[k] = 128'd0; rsp_has[k] = 0; rsp_ff[k] = 5'd0;
        end
    endtask

    task automatic req(input int k, input logic [1:0] wid, input logic [63:0] meta, input bit sop, input bit eop);
        req_valid[k] = 1; req_wid[k] = wid; req_meta[k] = meta; req_sop[k] = sop; req_eop[k] = eop;
    endtask

    task automatic rsp(input int k, input int tag, input bit has, input logic [4:0] ff);
        rsp_valid[k] = 1; rsp_tag[k] = 2'(tag); rsp_has[k] = has; rsp_ff[k] = ff;
        rsp_result[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        idle_all();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    initial begin : main
        int cand [$];
        idle_all();
        out_ready[0] = 1; out_ready[1] = 1;
        reset_n = 0;
        tick();
        started = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_count", count[k], 3'd0);
            chk("rst_empty", empty[k], 1'b1);
            chk("rst_req_ready", req_ready[k], 1'b1);
            chk("rst_req_tag", req_tag[k], 2'd0);
            chk("rst_out_valid", out_valid[k], rsp_valid[k]);
            chk("rst_csr_we", csr_we[k], 1'b0);
        end
        reset_n = 1;

        // reorder: issue 0,1,2 then respond 2,0,1
        for (int i = 0; i < 3; i++) begin
            req(0, 2'd0, 64'd100 + 64'(i), 1, 1);
            tick();
        end
        req_valid[0] = 0;
        seen0.delete();
        rsp(0, 2, 0, 5'd0); tick();
        chk("A_no_early", out_valid[0], 1'b0);
        rsp(0, 0, 0, 5'd0); tick();
        chk("A_lat1", out_valid[0], 1'b1);
        chk("A_meta0", out_meta[0], 64'd100);
        rsp(0, 1, 0, 5'd0); tick();
        chk("A_b2b1", out_valid[0], 1'b1);
        chk("A_meta1", out_meta[0], 64'd101);
        rsp_valid[0] = 0; tick();
        chk("A_b2b2", out_valid[0], 1'b1);
        chk("A_meta2", out_meta[0], 64'd102);
        tick();
        chk("A_seen_n", seen0.size(), 3);
        if (seen0.size() == 3) begin
            chk("A_order0", seen0[0], 64'd100);
            chk("A_order1", seen0[1], 64'd101);
            chk("A_order2", seen0[2], 64'd102);
        end

        // fill, then release and request in the same cycle
        do_reset();
        out_ready[0] = 0;
        for (int i = 0; i < 4; i++) begin
            req(0, 2'd1, 64'd200 + 64'(i), 1, 1);
            tick();
        end
        req_valid[0] = 0;
        chk("B_full_ready", req_ready[0], 1'b0);
        chk("B_full_count", count[0], 3'd4);
        rsp(0, 0, 0, 5'd0); tick();
        rsp_valid[0] = 0;
        out_ready[0] = 1;
        req(0, 2'd1, 64'd210, 1, 1);
        #1;
        chk("B_no_bypass", req_ready[0], 1'b0);
        tick();
        chk("B_count3", count[0], 3'd3);
        chk("B_ready", req_ready[0], 1'b1);
        chk("B_wrap_tag", req_tag[0], 2'd0);
        out_ready[0] = 0;
        tick();
        req_valid[0] = 0;
        chk("B_refill", count[0], 3'd4);

        // fflags accumulation on warp 2: NX, none, OF
        do_reset();
        out_ready[0] = 1;
        pulses[0] = 0;
        req(0, 2'd2, 64'd500, 1, 0); tick();
        req(0, 2'd2, 64'd501, 0, 0); tick();
        req(0, 2'd2, 64'd502, 0, 1); tick();
        req_valid[0] = 0;
        rsp(0, 0, 1, 5'b00001); tick();
        rsp(0, 1, 0, 5'b11111); tick();
        rsp(0, 2, 1, 5'b00100); tick();
        rsp_valid[0] = 0;
        repeat (3) tick();
        chk("C_pulses", pulses[0], 1);
        chk("C_wid", last_wid[0], 2'd2);
        chk("C_ff", last_ff[0], 5'b00101);
        pulses[0] = 0;
        req(0, 2'd2, 64'd510, 1, 1); tick();
        req_valid[0] = 0;
        rsp(0, 3, 0, 5'd0); tick();
        rsp_valid[0] = 0;
        repeat (3) tick();
        chk("D_no_pulse", pulses[0], 0);

        // pass-through with stalled commit
        do_reset();
        out_ready[1] = 0;
        for (int i = 0; i < 4; i++) begin
            req(1, 2'(i), 64'd300 + 64'(i), 1, 1);
            tick();
        end
        req_valid[1] = 0;
        rsp(1, 3, 0, 5'd0);
        #1;
        chk("E_stall_rdy", rsp_ready[1], 1'b0);
        chk("E_valid", out_valid[1], 1'b1);
        chk("E_meta3", out_meta[1], 64'd303);
        tick();
        chk("E_stall_rdy2", rsp_ready[1], 1'b0);
        chk("E_meta3b", out_meta[1], 64'd303);
        tick();
        out_ready[1] = 1;
        #1;
        chk("E_rdy", rsp_ready[1], 1'b1);
        tick();
        rsp_valid[1] = 0;
        #1;
        chk("E_count3", count[1], 3'd3);
        chk("E_free3", req_tag[1], 2'd3);
        rsp(1, 1, 0, 5'd0);
        tick();
        rsp_valid[1] = 0;
        #1;
        chk("E_free1", req_tag[1], 2'd1);

        // reset with entries pending and warp 1 partially accumulated
        do_reset();
        out_ready[0] = 1;
        for (int i = 0; i < 4; i++) begin
            req(0, 2'd1, 64'd400 + 64'(i), i == 0, 0);
            tick();
        end
        req_valid[0] = 0;
        rsp(0, 0, 1, 5'b10000); tick();
        rsp_valid[0] = 0; tick();
        chk("F_pending", count[0], 3'd3);
        pulses[0] = 0;
        reset_n = 0; tick();
        reset_n = 1;
        chk("F_count", count[0], 3'd0);
        chk("F_empty", empty[0], 1'b1);
        chk("F_out_valid", out_valid[0], 1'b0);
        chk("F_csr", csr_we[0], 1'b0);
        chk("F_tag", req_tag[0], 2'd0);
        req(0, 2'd1, 64'd420, 1, 1); tick();
        req_valid[0] = 0;
        rsp(0, 0, 0, 5'd0); tick();
        rsp_valid[0] = 0;
        repeat (3) tick();
        chk("F_acc_cleared", pulses[0], 0);

        // randomized traffic on both instances
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                req_valid[k] = ($urandom % 3) != 0;
                req_wid[k] = 2'($urandom);
                req_meta[k] = {$urandom, $urandom};
                req_sop[k] = 1'($urandom);
                req_eop[k] = ($urandom % 3) == 0;
                out_ready[k] = ($urandom % 4) != 0;
                cand.delete();
                for (int i = 0; i < D; i++) if (m_v[k][i] && (k == 1 || !m_done[0][i])) cand.push_back(i);
                if (cand.size() > 0 && ($urandom % 2) == 1) begin
                    rsp(k, cand[$urandom % cand.size()], 1'($urandom), 5'($urandom));
                end else begin
                    rsp_valid[k] = 0;
                end
            end
            tick();
        end
        idle_all();
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
